mem_bist_ctrl: RTL

Hardware built-in self-test controller that acts as the initiator on the single-port synchronous memory interface (`read`, `write`, `addr`, `data_in`, `data_out`). On `start` it runs a four-phase march: write 0 everywhere, read and check 0, write the address pattern, then read and check it. It reports pass/fail, an error count and the first failing location. It sits beside each memory instance and replaces bench-driven memory checks in system-level builds.

---
 rtl/mem_bist_pkg.sv | 20 ++
 rtl/mem_bist_checker.sv | 60 ++++++
 rtl/mem_bist_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
// Holds the march state encoding and the data-pattern selectors.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ZERO,
        RD_ZERO,
        WR_ADDR,
        RD_ADDR,
        DONE
    } bist_state_t;

    // Data pattern used by the current phase: all zeros or the address itself.
    localparam logic PAT_ZERO = 1'b0;
    localparam logic PAT_ADDR = 1'b1;

    localparam int DEFAULT_ERR_WIDTH = 16;

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data checker: aligns expected data with the registered memory output,
// counts mismatches (saturating) and captures the first failing location.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    logic                  chk_v;
    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic                  mismatch;

    assign mismatch = chk_v && (data_out != chk_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_v       <= 1'b0;
            chk_addr    <= '0;
            chk_exp     <= '0;
            error_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            // Memory output is registered, so the strobe's address and
            // expectation ride one cycle behind it to meet the data.
            chk_v    <= rd;
            chk_addr <= addr;
            chk_exp  <= exp_data;
            if (clr) begin
                error_count <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
            end else if (mismatch) begin
                if (error_count != '1) begin
                    error_count <= error_count + ERR_WIDTH'(1);
                end
                // A zero count means no earlier mismatch in this run.
                if (error_count == '0) begin
                    fail_addr <= chk_addr;
                    fail_data <= data_out;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March BIST initiator: write 0, read 0, write address pattern, read it back.
// Owns the phase FSM and address counter; all memory strobes are registered.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 512,
    parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    // One extra counter bit lets read phases count through the drain slot
    // (cnt == MEM_DEPTH) without wrapping.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(MEM_DEPTH);

    bist_state_t           state, next_state;
    logic [CNT_W-1:0]      cnt, next_cnt;
    logic                  start_ok;
    logic                  pat_sel;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  nxt_read, nxt_write;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0] nxt_data, nxt_exp;
    logic [DATA_WIDTH-1:0] exp_data;

    assign start_ok = start && (state == IDLE || state == DONE);

    // State register, counter and registered memory strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            exp_data    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state       <= next_state;
            cnt         <= next_cnt;
            mem_read    <= nxt_read;
            mem_write   <= nxt_write;
            mem_addr    <= nxt_addr;
            mem_data_in <= nxt_data;
            exp_data    <= nxt_exp;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (latch).
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = WR_ZERO;
                    next_cnt   = '0;
                end
            end
            WR_ZERO: begin
                if (cnt == LAST_WR) begin
                    next_state = RD_ZERO;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            RD_ZERO: begin
                if (cnt == LAST_RD) begin
                    next_state = WR_ADDR;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            WR_ADDR: begin
                if (cnt == LAST_WR) begin
                    next_state = RD_ADDR;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            RD_ADDR: begin
                if (cnt == LAST_RD) begin
                    next_state = DONE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Strobes are decoded from the upcoming state so they register in step with it.
    always_comb begin
        pat_sel   = (next_state == WR_ADDR || next_state == RD_ADDR) ? PAT_ADDR : PAT_ZERO;
        nxt_write = (next_state == WR_ZERO || next_state == WR_ADDR);
        nxt_read  = (next_state == RD_ZERO || next_state == RD_ADDR) && (next_cnt != LAST_RD);
        nxt_addr  = (nxt_read || nxt_write) ? next_cnt[ADDR_WIDTH-1:0] : '0;
        pattern   = (pat_sel == PAT_ADDR) ? DATA_WIDTH'(next_cnt[ADDR_WIDTH-1:0]) : '0;
        nxt_data  = nxt_write ? pattern : '0;
        nxt_exp   = nxt_read ? pattern : '0;
    end

    assign busy = (state == WR_ZERO) || (state == RD_ZERO) ||
                  (state == WR_ADDR) || (state == RD_ADDR);
    assign done = (state == DONE);
    assign pass = done && (error_count == '0);

    mem_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_ok),
        .rd          (mem_read),
        .addr        (mem_addr),
        .exp_data    (exp_data),
        .data_out    (mem_data_out),
        .error_count (error_count),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data)
    );

endmodule
